// File: rtl/fp16mult_arb_pkg.sv
// Shared types and the round-robin pick helper for the fp16mult arbiter.
package fp16mult_arb_pkg;

  localparam int FP16_W   = 16;
  localparam int ID_MAX_W = 4;

  typedef logic [FP16_W-1:0] fp16_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    fp16_t               data;
  } arb_entry_t;

  // Index of the first set bit searching from ptr+1, wrapping at n.
  // Returns ptr when nothing is set; callers gate on |valid.
  function automatic logic [ID_MAX_W-1:0] rr_pick(input logic [15:0]         valid,
                                                  input logic [ID_MAX_W-1:0] ptr,
                                                  input int                  n);
    logic [ID_MAX_W-1:0] win;
    logic                found;
    int                  idx;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k <= n && !found && valid[idx[3:0]]) begin
        win   = ID_MAX_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/fp16mult.sv
// Fixed-latency fp16 multiplier: subnormal inputs/underflow give signed zero,
// Inf/NaN inputs and overflow give signed Inf, mantissa truncated.
module fp16mult
  import fp16mult_arb_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  fp16_t a,
  input  fp16_t b,
  output fp16_t x
);

  logic        s;
  logic [21:0] prod;
  logic [9:0]  mant;
  int          e;
  fp16_t       y;
  fp16_t       stage [LATENCY];

  always_comb begin
    s    = a[15] ^ b[15];
    prod = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e    = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (prod[21]) begin
      mant = prod[20:11];
      e    = e + 1;
    end else begin
      mant = prod[19:10];
    end
    if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) y = {s, 5'h1f, 10'h000};
    else if (a[14:10] == 5'h00 || b[14:10] == 5'h00) y = {s, 15'h0000};
    else if (e >= 31) y = {s, 5'h1f, 10'h000};
    else if (e <= 0) y = {s, 15'h0000};
    else y = {s, e[4:0], mant};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= y;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign x = stage[LATENCY-1];

endmodule

// File: rtl/fp16mult_arb_fifo.sv
// Result FIFO for the arbiter: registered storage, combinational head,
// extra pointer bit separates full from empty.
module fp16mult_arb_fifo
  import fp16mult_arb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  arb_entry_t din,
  input  logic       pop,
  output arb_entry_t dout,
  output logic       empty,
  output logic [AW:0] count
);

  arb_entry_t  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  // When full, a push is only accepted alongside a pop that frees the slot.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fp16mult_arbiter.sv
// Round-robin sharing of one fp16mult among NREQ requesters with credit-based
// issue into a tagged result FIFO. FP16MULT_ARB_PRIO_EN adds prio_mask.
module fp16mult_arbiter
  import fp16mult_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef FP16MULT_ARB_PRIO_EN
  input  logic [NREQ-1:0]        prio_mask,
`endif
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [FP16_W*NREQ-1:0] req_a,
  input  logic [FP16_W*NREQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output fp16_t                  rsp_data,
  output logic                   busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                run;
  logic [IDW-1:0]      ptr;
  logic [IDW-1:0]      win;
  logic [NREQ-1:0]     eff_valid;
  logic [15:0]         v16;
  logic [ID_MAX_W-1:0] p4;
  logic [ID_MAX_W-1:0] w4;
  int                  used;
  logic                issue;
  fp16_t               mul_a;
  fp16_t               mul_b;
  fp16_t               mul_x;

  logic [LATENCY-1:0]  tag_v;
  logic [IDW-1:0]      tag_id [LATENCY];

  logic                fifo_pop;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  arb_entry_t          fifo_din;
  arb_entry_t          fifo_dout;
  logic                unused_id_bits;

  always_comb begin
`ifdef FP16MULT_ARB_PRIO_EN
    eff_valid = (|(req_valid & prio_mask)) ? (req_valid & prio_mask) : req_valid;
`else
    eff_valid = req_valid;
`endif
  end

  // Slots already spoken for: in flight plus buffered, less a same-cycle pop.
  always_comb begin
    v16            = '0;
    v16[NREQ-1:0]  = eff_valid;
    p4             = '0;
    p4[IDW-1:0]    = ptr;
    w4             = rr_pick(v16, p4, NREQ);
    win            = w4[IDW-1:0];
    used           = int'(fifo_count) - int'(fifo_pop);
    for (int i = 0; i < LATENCY; i++) used = used + int'(tag_v[i]);
    issue          = run && (used < FIFO_DEPTH) && (|eff_valid);
    req_ready      = '0;
    mul_a          = '0;
    mul_b          = '0;
    if (issue) begin
      req_ready[win] = 1'b1;
      mul_a          = req_a[win*FP16_W +: FP16_W];
      mul_b          = req_b[win*FP16_W +: FP16_W];
    end
  end

  // run keeps req_ready low while reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run   <= 1'b0;
      ptr   <= IDW'(NREQ - 1);
      tag_v <= '0;
      for (int i = 0; i < LATENCY; i++) tag_id[i] <= '0;
    end else begin
      run       <= 1'b1;
      if (issue) ptr <= win;
      tag_v[0]  <= issue;
      tag_id[0] <= win;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  fp16mult #(
    .LATENCY (LATENCY)
  ) u_mul (
    .clk (clk),
    .rst (rst),
    .a   (mul_a),
    .b   (mul_b),
    .x   (mul_x)
  );

  always_comb begin
    fifo_din              = '0;
    fifo_din.id[IDW-1:0]  = tag_id[LATENCY-1];
    fifo_din.data         = mul_x;
  end

  assign fifo_pop = rsp_valid && rsp_ready;

  fp16mult_arb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_v[LATENCY-1]),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rsp_valid      = !fifo_empty;
  assign rsp_id         = fifo_dout.id[IDW-1:0];
  assign rsp_data       = fifo_dout.data;
  assign busy           = (|tag_v) || !fifo_empty;
  assign unused_id_bits = ^fifo_dout.id;

endmodule

// File: tb/tb_fp16mult_arbiter.sv
// Scoreboard bench for fp16mult_arbiter (NREQ=4, LATENCY=2, FIFO_DEPTH=4).
module tb_fp16mult_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        busy;
`ifdef FP16MULT_ARB_PRIO_EN
  logic [3:0]  prio_mask;
`endif

  typedef struct {
    logic [3:0]  id;
    logic [15:0] data;
  } exp_t;

  exp_t        sbq [$];
  int          glog [$];
  logic [15:0] exp_prod [4];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  fp16mult_arbiter #(
    .NREQ       (4),
    .LATENCY    (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef FP16MULT_ARB_PRIO_EN
    .prio_mask (prio_mask),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Grants push the expected result; response handshakes pop and compare.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        sbq.push_back('{id: 4'(i), data: exp_prod[i]});
        glog.push_back(i);
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] p);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    exp_prod[i]       = p;
  endtask

  task automatic issue_one(input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] p);
    int n;
    tick();
    set_op(i, a, b, p);
    req_valid[i] = 1'b1;
    n = 0;
    do begin
      look();
      n++;
    end while (!req_ready[i] && n < 20);
    check("grant_seen", 32'(req_ready[i]), 1);
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      look();
      n++;
    end while ((busy || sbq.size() > 0) && n < 60);
    check("drain_busy", 32'(busy), 0);
    check("drain_sb_empty", sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_prod[i] = '0;
`ifdef FP16MULT_ARB_PRIO_EN
    prio_mask = '0;
`endif
    #1 rst = 1'b0;
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    look();
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_busy", 32'(busy), 0);
    tick();
    req_valid = '0;
    rst       = 1'b1;
    tick();

    // Single op: issue edge T, response visible after T+2.
    set_op(0, 16'h3C00, 16'h4000, 16'h4000);
    req_valid = 4'b0001;
    look();
    check("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    look();
    check("single_v_t0", 32'(rsp_valid), 0);
    tick();
    look();
    check("single_v_t1", 32'(rsp_valid), 0);
    tick();
    look();
    check("single_v_t2", 32'(rsp_valid), 1);
    check("single_busy", 32'(busy), 1);
    tick();
    look();
    check("single_idle", 32'(busy), 0);

    // Round robin: pointer sits at 0 after the single op, so order starts at 1.
    tick();
    for (int i = 0; i < 4; i++) set_op(i, 16'h3E00, 16'h4000, 16'h4200);
    glog.delete();
    req_valid = 4'hF;
    repeat (8) tick();
    req_valid = '0;
    check("rr_count", glog.size(), 8);
    for (int k = 0; k < glog.size() && k < 8; k++) check("rr_order", glog[k], (k + 1) % 4);
    drain();

    // Backpressure: four grants fill the credit budget, issue resumes on first pop.
    rsp_ready = 1'b0;
    tick();
    set_op(1, 16'h3C00, 16'h4000, 16'h4000);
    glog.delete();
    req_valid = 4'b0010;
    repeat (10) tick();
    look();
    check("bp_grants", glog.size(), 4);
    check("bp_ready_low", 32'(req_ready), 0);
    check("bp_rsp_valid", 32'(rsp_valid), 1);
    tick();
    rsp_ready = 1'b1;
    look();
    check("bp_resume", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    drain();
    check("bp_total", glog.size(), 5);

    // Special values.
    issue_one(0, 16'h0000, 16'h4000, 16'h0000);
    issue_one(1, 16'h8200, 16'h3C00, 16'h8000);
    issue_one(3, 16'h7C00, 16'h3C00, 16'h7C00);
    issue_one(2, 16'h3E00, 16'h4000, 16'h4200);
    drain();

    // Full FIFO, then sustained push/pop with a requester still streaming.
    rsp_ready = 1'b0;
    tick();
    set_op(2, 16'h4000, 16'h4000, 16'h4400);
    glog.delete();
    req_valid = 4'b0100;
    repeat (8) tick();
    look();
    check("full_grants", glog.size(), 4);
    tick();
    rsp_ready = 1'b1;
    glog.delete();
    for (int k = 0; k < 6; k++) begin
      look();
      check("pp_rsp_valid", 32'(rsp_valid), 1);
      tick();
    end
    req_valid = '0;
    check("pp_grants", glog.size(), 6);
    drain();

    // Async reset with three ops outstanding.
    rsp_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) set_op(i, 16'h3C00, 16'h3C00, 16'h3C00);
    glog.delete();
    req_valid = 4'hF;
    repeat (3) tick();
    check("mid_grants", glog.size(), 3);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(req_ready), 0);
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_id", 32'(rsp_id), 0);
    check("mid_rst_data", 32'(rsp_data), 0);
    check("mid_rst_busy", 32'(busy), 0);
    sbq.delete();
    glog.delete();
    rsp_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    begin
      int n;
      n = 0;
      do begin
        look();
        if (glog.size() == 0) check("post_rst_no_rsp", 32'(rsp_valid), 0);
        n++;
      end while (glog.size() == 0 && n < 10);
      check("post_rst_grant_seen", 32'(glog.size() > 0), 1);
      if (glog.size() > 0) check("post_rst_first", glog[0], 0);
    end
    tick();
    req_valid = '0;
    drain();

`ifdef FP16MULT_ARB_PRIO_EN
    tick();
    for (int i = 0; i < 4; i++) set_op(i, 16'h3E00, 16'h4000, 16'h4200);
    prio_mask = 4'b0100;
    glog.delete();
    req_valid = 4'hF;
    repeat (6) tick();
    req_valid = '0;
    prio_mask = '0;
    check("prio_count", glog.size(), 6);
    for (int k = 0; k < glog.size(); k++) check("prio_winner", glog[k], 2);
    drain();
`endif

    check("final_sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
